// File: rtl/player_input_pkg.sv
// Operation codes shared by the player input, display and game controller,
// plus the press-to-code helper used by the input FSM.
package player_input_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_UP    = 4'd0;
  localparam logic [OP_W-1:0] OP_DOWN  = 4'd1;
  localparam logic [OP_W-1:0] OP_LEFT  = 4'd2;
  localparam logic [OP_W-1:0] OP_RIGHT = 4'd3;
  localparam logic [OP_W-1:0] OP_NONE  = 4'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  // Anything other than exactly one pressed button maps to OP_NONE.
  function automatic logic [OP_W-1:0] btn_to_op(input logic [3:0] levels);
    logic [OP_W-1:0] code;
    case (levels)
      4'b0001: code = OP_UP;
      4'b0010: code = OP_DOWN;
      4'b0100: code = OP_LEFT;
      4'b1000: code = OP_RIGHT;
      default: code = OP_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/player_input_if.sv
// Button-side controls and operation outputs of the player input block.
interface player_input_if;
  import player_input_pkg::*;

  logic            enable;
  logic            clear;
  logic [3:0]      btn;
  logic [OP_W-1:0] operation;
  logic            op_valid;
  logic            op_multi;
  logic            busy;

  modport master (
    output enable, clear, btn,
    input  operation, op_valid, op_multi, busy
  );

  modport slave (
    input  enable, clear, btn,
    output operation, op_valid, op_multi, busy
  );

endinterface

// File: rtl/player_input_btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce counter
// for one raw button line.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any return to the debounced level restarts the count from zero.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign db = db_q;

endmodule

// File: rtl/player_input.sv
// Turns four debounced direction buttons into one operation code per press.
//   state   | meaning
//   IDLE    | no button held; the next press edge is evaluated
//   HELD    | a press was seen; wait for every button to release
module player_input
  import player_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  player_input_if.slave  io
);

  logic [3:0]      db;
  logic [3:0]      db_prev_q;
  logic [3:0]      rise;
  logic [OP_W-1:0] press_code;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            valid_q, valid_d;
  logic            multi_q, multi_d;

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (io.btn[i]),
      .db    (db[i])
    );
  end

  assign rise       = db & ~db_prev_q;
  assign press_code = btn_to_op(db);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_q <= 4'b0000;
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      db_prev_q <= db;
      state_q   <= state_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
    end
  end

  // clear is applied first so that an accept on the same edge overrides it.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    valid_d = 1'b0;
    multi_d = 1'b0;
    if (io.clear) begin
      op_d = OP_NONE;
    end
    case (state_q)
      ST_IDLE: begin
        if (|rise) begin
          state_d = ST_HELD;
          if (io.enable) begin
            if (press_code != OP_NONE) begin
              op_d    = press_code;
              valid_d = 1'b1;
            end else begin
              multi_d = 1'b1;
            end
          end
        end
      end
      ST_HELD: begin
        if (db == 4'b0000) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign io.operation = op_q;
  assign io.op_valid  = valid_q;
  assign io.op_multi  = multi_q;
  assign io.busy      = (state_q == ST_HELD);

endmodule

// File: tb/tb_player_input.sv
// Randomised + directed bench for player_input with a queue-based scoreboard
// fed by a sample-window reference model.
module tb_player_input;
  import player_input_pkg::*;

  localparam int DC = 4;
  localparam int CW = 3;

  typedef struct {
    bit         multi;
    logic [3:0] op;
    int         cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  player_input_if bus();

  player_input #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ev_t        exp_q[$];
  logic [3:0] hist[$];
  logic [3:0] mdb, mdb_prev;
  bit         mheld;
  logic [3:0] mop;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < DC + 2; i++) hist.push_back(4'b0000);
    mdb      = 4'b0000;
    mdb_prev = 4'b0000;
    mheld    = 1'b0;
    mop      = OP_NONE;
  endfunction

  // A button's debounced level flips once the last DC synchronised samples
  // (raw samples delayed by two edges) all disagree with it.
  task automatic model_step();
    logic [3:0] rise, newdb, s;
    int         sz;
    bit         flip;
    ev_t        e;
    cyc++;
    rise = mdb & ~mdb_prev;
    if (bus.clear) mop = OP_NONE;
    if (mheld) begin
      if (mdb == 4'b0000) mheld = 1'b0;
    end else if (rise != 4'b0000) begin
      mheld = 1'b1;
      if (bus.enable) begin
        if ($countones(mdb) == 1) begin
          for (int i = 0; i < 4; i++) if (mdb[i]) mop = 4'(i);
          e.multi = 1'b0;
        end else begin
          e.multi = 1'b1;
        end
        e.op  = mop;
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
    hist.push_back(bus.btn);
    sz = hist.size();
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int k = sz - 2 - DC; k <= sz - 3; k++) begin
        s = hist[k];
        if (s[b] == mdb[b]) flip = 1'b0;
      end
      newdb[b] = flip ? ~mdb[b] : mdb[b];
    end
    mdb_prev = mdb;
    mdb      = newdb;
    if (hist.size() > 32) void'(hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Monitor: compares held outputs every cycle and pops the scoreboard on pulses.
  initial begin
    ev_t e;
    bit  pulse, due;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("operation", bus.operation, mop);
        chk("busy", bus.busy, mheld);
        chk("valid_and_multi", bus.op_valid & bus.op_multi, 0);
        pulse = bus.op_valid | bus.op_multi;
        due   = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        chk("pulse_present", pulse, due);
        if (due) begin
          e = exp_q.pop_front();
          if (pulse) begin
            chk("pulse_kind_multi", bus.op_multi, e.multi);
            chk("pulse_op", bus.operation, e.op);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hold;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.btn    = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("rst_operation", bus.operation, OP_NONE);
    chk("rst_valid", bus.op_valid, 0);
    chk("rst_multi", bus.op_multi, 0);
    chk("rst_busy", bus.busy, 0);

    // single left press: pulse exactly 7 edges after first sampling edge
    bus.enable = 1'b1;
    bus.btn    = 4'b0100;
    tick(6);
    chk("left_early", bus.op_valid, 0);
    tick(1);
    chk("left_pulse", bus.op_valid, 1);
    chk("left_op", bus.operation, OP_LEFT);
    tick(13);
    chk("left_busy", bus.busy, 1);
    bus.btn = 4'b0000;
    tick(12);
    chk("left_released", bus.busy, 0);

    // bouncing up button, then stable
    for (int i = 0; i < 10; i++) begin
      bus.btn = bus.btn ^ 4'b0001;
      tick(2);
    end
    bus.btn = 4'b0001;
    tick(15);
    chk("bounce_op", bus.operation, OP_UP);
    bus.btn = 4'b0000;
    tick(12);

    // simultaneous up+right
    bus.btn = 4'b1001;
    tick(15);
    chk("multi_op_kept", bus.operation, OP_UP);
    chk("multi_busy", bus.busy, 1);
    bus.btn = 4'b0000;
    tick(12);

    // disabled press, then enabled down
    bus.enable = 1'b0;
    bus.btn    = 4'b1000;
    tick(15);
    bus.btn = 4'b0000;
    tick(12);
    chk("disabled_op", bus.operation, OP_UP);
    bus.enable = 1'b1;
    bus.btn    = 4'b0010;
    tick(15);
    chk("down_op", bus.operation, OP_DOWN);
    bus.btn = 4'b0000;
    tick(12);

    // clear on the accept edge, then clear alone
    bus.btn = 4'b0001;
    tick(6);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("clear_accept_valid", bus.op_valid, 1);
    chk("clear_accept_op", bus.operation, OP_UP);
    bus.btn = 4'b0000;
    tick(12);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("clear_alone_op", bus.operation, OP_NONE);

    // asynchronous reset while HELD, button still held afterwards
    bus.btn = 4'b0100;
    tick(12);
    chk("pre_reset_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_operation", bus.operation, OP_NONE);
    chk("async_rst_valid", bus.op_valid, 0);
    chk("async_rst_multi", bus.op_multi, 0);
    chk("async_rst_busy", bus.busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("post_reset_press", bus.operation, OP_LEFT);
    bus.btn = 4'b0000;
    tick(12);

    // randomised presses, bounces, enable and clear activity
    repeat (180) begin
      case ($urandom_range(0, 3))
        0:       bus.btn = 4'b0000;
        1, 2:    bus.btn = 4'b0001 << $urandom_range(0, 3);
        default: bus.btn = 4'($urandom_range(0, 15));
      endcase
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.clear  = ($urandom_range(0, 15) == 0);
      hold = $urandom_range(1, 12);
      tick(1);
      bus.clear = 1'b0;
      tick(hold);
    end
    bus.btn = 4'b0000;
    tick(20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
